// File: rtl/sd_cmd_rx_ctrl.sv
// rtl/sd_cmd_rx_ctrl.sv - SD host-command receive sequencer (pin sync, framing, CRC7, handoff)
module sd_cmd_rx_ctrl #(
  parameter int RESYNC_ONES = 8,
  parameter bit STRICT_CRC  = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        sd_clk_i,
  input  logic        sd_cmd_i,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic        crc_err,
  output logic        frame_err,
  output logic        overflow,
  output logic        busy
);

  localparam int OW = $clog2(RESYNC_ONES + 1);
  localparam logic [OW-1:0] ONES_MAX = OW'(RESYNC_ONES);

  localparam logic [2:0] S_RESYNC = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_SHIFT  = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;

  // The start bit (frame bit 47) is implicit, so the shift register keeps bits 46..0.
  logic [2:0]    clk_sync_q, clk_sync_d, cmd_sync_q, cmd_sync_d;
  logic          clk_prev_q, clk_prev_d;
  logic [2:0]    state_q, state_d;
  logic [OW-1:0] ones_q, ones_d;
  logic [5:0]    bit_cnt_q, bit_cnt_d;
  logic [46:0]   shift_q, shift_d;
  logic [6:0]    crc_q, crc_d;
  logic          cmd_valid_q, cmd_valid_d, crc_err_q, crc_err_d;
  logic          frame_err_q, frame_err_d, overflow_q, overflow_d, drop_q, drop_d;
  logic [5:0]    cmd_index_q, cmd_index_d;
  logic [31:0]   cmd_arg_q, cmd_arg_d;

  logic          sample, sbit, handshake, crc_ok, frame_ok;
  logic [2:0]    eff_state;
  logic [OW-1:0] ones_cur, ones_nxt;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:3], c[2] ^ fb, c[1:0], fb};
  endfunction

  assign sample    = clk_sync_q[2] & ~clk_prev_q;
  assign sbit      = cmd_sync_q[2];
  assign handshake = (state_q == S_HOLD) && cmd_ready;
  assign crc_ok    = (shift_q[7:1] == crc_q);
  assign frame_ok  = shift_q[46] & shift_q[0];

  assign cmd_valid = cmd_valid_q;
  assign cmd_index = cmd_index_q;
  assign cmd_arg   = cmd_arg_q;
  assign crc_err   = crc_err_q;
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;
  assign busy      = (state_q == S_SHIFT) || (state_q == S_CHECK);

  // Next-state logic; a handshake in HOLD first moves to IDLE/RESYNC so a coincident sample is handled there.
  always_comb begin
    clk_sync_d  = {clk_sync_q[1:0], sd_clk_i};
    cmd_sync_d  = {cmd_sync_q[1:0], sd_cmd_i};
    clk_prev_d  = clk_sync_q[2];
    state_d     = state_q;
    ones_d      = ones_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    crc_d       = crc_q;
    cmd_valid_d = cmd_valid_q;
    crc_err_d   = crc_err_q;
    frame_err_d = frame_err_q;
    overflow_d  = 1'b0;
    drop_d      = drop_q;
    cmd_index_d = cmd_index_q;
    cmd_arg_d   = cmd_arg_q;
    eff_state   = state_q;
    ones_cur    = ones_q;
    ones_nxt    = ones_q;

    if (handshake) begin
      cmd_valid_d = 1'b0;
      crc_err_d   = 1'b0;
      frame_err_d = 1'b0;
      drop_d      = 1'b0;
      eff_state   = drop_q ? S_RESYNC : S_IDLE;
      ones_cur    = '0;
      ones_d      = '0;
      state_d     = eff_state;
    end

    case (eff_state)
      S_RESYNC: begin
        if (sample) begin
          if (!sbit)                  ones_nxt = '0;
          else if (ones_cur == ONES_MAX) ones_nxt = ONES_MAX;
          else                        ones_nxt = ones_cur + 1'b1;
          ones_d = ones_nxt;
          if (ones_nxt == ONES_MAX) state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        crc_err_d   = 1'b0;
        frame_err_d = 1'b0;
        if (sample && !sbit) begin
          state_d   = S_SHIFT;
          bit_cnt_d = 6'd1;
          shift_d   = '0;
          crc_d     = crc7_step(7'd0, 1'b0);
        end
      end
      S_SHIFT: begin
        if (sample) begin
          shift_d   = {shift_q[45:0], sbit};
          bit_cnt_d = bit_cnt_q + 6'd1;
          if (bit_cnt_q < 6'd40) crc_d = crc7_step(crc_q, sbit);
          if (bit_cnt_q == 6'd47) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        bit_cnt_d   = '0;
        crc_err_d   = ~crc_ok;
        frame_err_d = ~frame_ok;
        if (!STRICT_CRC || (crc_ok && frame_ok)) begin
          cmd_index_d = shift_q[45:40];
          cmd_arg_d   = shift_q[39:8];
          cmd_valid_d = 1'b1;
          state_d     = S_HOLD;
        end else begin
          state_d     = S_IDLE;
        end
      end
      S_HOLD: begin
        // Only the first start bit of an overrun frame is reported; the rest of it is ignored.
        if (sample && !sbit && !drop_q) begin
          overflow_d = 1'b1;
          drop_d     = 1'b1;
        end
      end
      default: state_d = S_RESYNC;
    endcase

    if (!enable) begin
      state_d     = S_RESYNC;
      ones_d      = '0;
      bit_cnt_d   = '0;
      shift_d     = '0;
      crc_d       = '0;
      cmd_valid_d = 1'b0;
      crc_err_d   = 1'b0;
      frame_err_d = 1'b0;
      overflow_d  = 1'b0;
      drop_d      = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync_q  <= '0;
      cmd_sync_q  <= '0;
      clk_prev_q  <= 1'b0;
      state_q     <= S_RESYNC;
      ones_q      <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      crc_q       <= '0;
      cmd_valid_q <= 1'b0;
      crc_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      drop_q      <= 1'b0;
      cmd_index_q <= '0;
      cmd_arg_q   <= '0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      cmd_sync_q  <= cmd_sync_d;
      clk_prev_q  <= clk_prev_d;
      state_q     <= state_d;
      ones_q      <= ones_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      crc_q       <= crc_d;
      cmd_valid_q <= cmd_valid_d;
      crc_err_q   <= crc_err_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
      drop_q      <= drop_d;
      cmd_index_q <= cmd_index_d;
      cmd_arg_q   <= cmd_arg_d;
    end
  end

endmodule

// File: tb/tb_sd_cmd_rx_ctrl.sv
// tb/tb_sd_cmd_rx_ctrl.sv - self-checking bench for sd_cmd_rx_ctrl (lenient and strict CRC instances)
module tb_sd_cmd_rx_ctrl;

  logic clk = 1'b0;
  logic reset, enable, sd_clk_i, sd_cmd_i, cmd_ready;
  logic v0, ce0, fe0, ov0, busy0, v1, ce1, fe1, ov1, busy1;
  logic [5:0]  idx0, idx1;
  logic [31:0] arg0, arg1;

  int checks = 0, failures = 0;
  int n_ovf0 = 0, n_ovf1 = 0, n_crc1 = 0, n_fe1 = 0, n_v1 = 0;
  int b_crc, b_fe, b_v, b_ovf0, b_ovf1, lat;
  logic v1_prev = 1'b0;
  logic [47:0] f;

  always #5 clk = ~clk;

  sd_cmd_rx_ctrl #(.RESYNC_ONES(8), .STRICT_CRC(1'b0)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .sd_clk_i(sd_clk_i), .sd_cmd_i(sd_cmd_i),
    .cmd_valid(v0), .cmd_ready(cmd_ready), .cmd_index(idx0), .cmd_arg(arg0),
    .crc_err(ce0), .frame_err(fe0), .overflow(ov0), .busy(busy0));

  sd_cmd_rx_ctrl #(.RESYNC_ONES(8), .STRICT_CRC(1'b1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .sd_clk_i(sd_clk_i), .sd_cmd_i(sd_cmd_i),
    .cmd_valid(v1), .cmd_ready(cmd_ready), .cmd_index(idx1), .cmd_arg(arg1),
    .crc_err(ce1), .frame_err(fe1), .overflow(ov1), .busy(busy1));

  always @(negedge clk) begin
    if (ov0 === 1'b1) n_ovf0++;
    if (ov1 === 1'b1) n_ovf1++;
    if (ce1 === 1'b1) n_crc1++;
    if (fe1 === 1'b1) n_fe1++;
    if (v1 === 1'b1 && v1_prev !== 1'b1) n_v1++;
    v1_prev = v1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // CRC7 as the remainder of data*x^7 divided by x^7+x^3+1.
  function automatic logic [6:0] ref_crc7(input logic [39:0] d);
    logic [46:0] r;
    r = {d, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r = r ^ (47'h89 << (i - 7));
    return r[6:0];
  endfunction

  function automatic logic [47:0] mk_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] d;
    d = {2'b01, idx, arg};
    return {d, ref_crc7(d), 1'b1};
  endfunction

  task automatic send_bit(input logic b);
    sd_cmd_i = b;
    repeat (3) @(negedge clk);
    sd_clk_i = 1'b1;
    repeat (3) @(negedge clk);
    sd_clk_i = 1'b0;
  endtask

  task automatic send_ones(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  // Sends a frame; lat = clk cycles from the end-bit CLK pin rise to cmd_valid on the lenient instance.
  task automatic send_frame(input logic [47:0] fr, output int l);
    b_crc = n_crc1; b_fe = n_fe1; b_v = n_v1;
    for (int i = 47; i >= 1; i--) send_bit(fr[i]);
    sd_cmd_i = fr[0];
    repeat (3) @(negedge clk);
    sd_clk_i = 1'b1;
    l = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (v0 === 1'b1 && l == 0) l = k;
    end
    sd_clk_i = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_rx(input string tag, input logic [47:0] fr, input int l);
    logic ce, fe, deliver;
    ce = (fr[7:1] != ref_crc7(fr[47:8]));
    fe = !(fr[46] && fr[0]);
    deliver = !ce && !fe;
    chk({tag, "_valid"}, v0, 1);
    chk({tag, "_index"}, idx0, fr[45:40]);
    chk({tag, "_arg"}, arg0, fr[39:8]);
    chk({tag, "_crc_err"}, ce0, ce);
    chk({tag, "_frame_err"}, fe0, fe);
    chk({tag, "_latency"}, l, 5);
    chk({tag, "_strict_valid"}, v1, deliver);
    chk({tag, "_strict_valid_rises"}, n_v1 - b_v, deliver);
    chk({tag, "_strict_crc_pulses"}, n_crc1 - b_crc, ce);
    chk({tag, "_strict_frame_pulses"}, n_fe1 - b_fe, fe);
    if (deliver) begin
      chk({tag, "_strict_index"}, idx1, fr[45:40]);
      chk({tag, "_strict_arg"}, arg1, fr[39:8]);
    end
  endtask

  task automatic ack(input string tag);
    @(negedge clk);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    chk({tag, "_valid_cleared"}, v0, 0);
    send_ones(2);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; sd_clk_i = 1'b0; sd_cmd_i = 1'b1; cmd_ready = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset_outputs", {v0, ce0, fe0, ov0, busy0, v1, busy1, idx0, arg0}, 0);
    reset = 1'b0;

    // CMD0 after idle ones
    send_ones(8);
    f = mk_frame(6'd0, 32'h0);
    chk("cmd0_crc_byte", f[7:0], 8'h95);
    send_frame(f, lat);
    check_rx("cmd0", f, lat);
    ack("cmd0");

    // CMD8
    f = mk_frame(6'd8, 32'h0000_01AA);
    chk("cmd8_crc_byte", f[7:0], 8'h87);
    send_frame(f, lat);
    check_rx("cmd8", f, lat);
    ack("cmd8");

    // CMD8 with argument bit 0 flipped
    f = mk_frame(6'd8, 32'h0000_01AA);
    f[8] = ~f[8];
    send_frame(f, lat);
    check_rx("cmd8_badcrc", f, lat);
    chk("cmd8_badcrc_flag", ce0, 1);
    ack("cmd8_badcrc");

    // Random frames, some corrupted
    for (int t = 0; t < 8; t++) begin
      int mode;
      mode = $urandom_range(0, 3);
      f = mk_frame(6'($urandom), $urandom);
      if (mode == 1) f[1 + $urandom_range(0, 6)] ^= 1'b1;
      if (mode == 2) f[46] = 1'b0;
      if (mode == 3) f[0] = 1'b0;
      send_frame(f, lat);
      check_rx($sformatf("rand%0d_m%0d", t, mode), f, lat);
      ack($sformatf("rand%0d", t));
    end

    // Overflow: second frame while the first is still held
    f = mk_frame(6'd8, 32'h0000_01AA);
    send_frame(f, lat);
    check_rx("ovf_first", f, lat);
    b_ovf0 = n_ovf0; b_ovf1 = n_ovf1;
    send_ones(2);
    send_frame(mk_frame(6'd0, 32'h0), lat);
    chk("ovf_pulses", n_ovf0 - b_ovf0, 1);
    chk("ovf_strict_pulses", n_ovf1 - b_ovf1, 1);
    chk("ovf_hold_valid", v0, 1);
    chk("ovf_hold_index", idx0, 6'd8);
    chk("ovf_hold_arg", arg0, 32'h0000_01AA);
    @(negedge clk); cmd_ready = 1'b1;
    @(negedge clk); cmd_ready = 1'b0;
    chk("ovf_valid_cleared", v0, 0);
    // Back in RESYNC: a frame without 8 leading ones must be ignored
    send_frame(mk_frame(6'd0, 32'h0), lat);
    chk("ovf_resync_ignores", v0, 0);
    send_ones(8);
    f = mk_frame(6'd0, 32'h0);
    send_frame(f, lat);
    check_rx("ovf_third", f, lat);
    ack("ovf_third");

    // Asynchronous reset mid-frame
    f = mk_frame(6'd8, 32'h0000_01AA);
    for (int i = 47; i >= 28; i--) send_bit(f[i]);
    chk("rst_busy_before", busy0, 1);
    #2 reset = 1'b1;
    #1 chk("rst_async_outputs", {v0, busy0, ce0, fe0, ov0, busy1}, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    send_ones(8);
    send_frame(f, lat);
    check_rx("after_rst", f, lat);
    ack("after_rst");

    // Enable dropped mid-frame
    f = mk_frame(6'd0, 32'h0);
    for (int i = 47; i >= 18; i--) send_bit(f[i]);
    chk("en_busy_before", busy0, 1);
    enable = 1'b0;
    @(negedge clk);
    chk("en_off_busy", busy0, 0);
    chk("en_off_valid", v0, 0);
    repeat (10) @(negedge clk);
    enable = 1'b1;
    repeat (10) @(negedge clk);
    chk("en_restored_no_valid", v0, 0);
    send_ones(8);
    f = mk_frame(6'd17, 32'hDEAD_BEEF);
    send_frame(f, lat);
    check_rx("after_en", f, lat);
    ack("after_en");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
